// File: rtl/image_send_pkg.sv
// Shared types for the frame mode sequencer: pixel mux modes, FSM states, counter width.
package image_send_pkg;

  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    RAW   = 2'd1,
    BLUR  = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAW   = 3'd1,
    ST_BLUR  = 3'd2,
    ST_DONE  = 3'd3,
    ST_REARM = 3'd4
  } seq_state_t;

  // Pixel mux select implied by a sequencer state.
  function automatic mode_t mode_of(input seq_state_t st);
    mode_t m;
    m = BLACK;
    unique case (st)
      ST_RAW:  m = RAW;
      ST_BLUR: m = BLUR;
      default: m = BLACK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/frame_tracker.sv
// Tracks frame boundaries on the pixel stream and flags sop/eop protocol violations.
module frame_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic sop,
  input  logic eop,
  input  logic valid,
  input  logic ready,
  output logic in_frame,
  output logic frame_end,
  output logic proto_err
);

  logic w_acc;
  logic w_in_frame_nxt;
  logic w_err;
  logic r_in_frame;
  logic r_proto_err;

  assign w_acc     = valid & ready;
  // Frame end is combinational so the FSM can switch mode on the eop edge itself.
  assign frame_end = w_acc & eop;

  always_comb begin
    w_in_frame_nxt = r_in_frame;
    if (w_acc) begin
      if (sop && eop)  w_in_frame_nxt = 1'b0;
      else if (sop)    w_in_frame_nxt = 1'b1;
      else if (eop)    w_in_frame_nxt = 1'b0;
    end
  end

  // A single-beat sop+eop frame is legal; only a stray eop outside a frame is an error.
  assign w_err = w_acc & ((sop & r_in_frame) | (eop & ~sop & ~r_in_frame));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_frame  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_in_frame  <= w_in_frame_nxt;
      r_proto_err <= r_proto_err | w_err;
    end
  end

  assign in_frame  = r_in_frame;
  assign proto_err = r_proto_err;

endmodule

// File: rtl/frame_mode_sequencer.sv
// Sequences RAW then BLUR frames per table visit, switching the pixel mux only on frame boundaries.
module frame_mode_sequencer
  import image_send_pkg::*;
#(
  parameter int unsigned RAW_FRAMES  = 1,
  parameter int unsigned BLUR_FRAMES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sop,
  input  logic                   eop,
  input  logic                   valid,
  input  logic                   ready,
  input  logic                   at_table,
  input  logic                   abort,
  output logic [1:0]             mode,
  output logic                   blur_en,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   proto_err
);

  localparam logic [FRAME_CNT_W-1:0] RAW_LIM  = FRAME_CNT_W'(RAW_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BLUR_LIM = FRAME_CNT_W'(BLUR_FRAMES);

  logic                   w_acc;
  logic                   w_in_frame;
  logic                   w_frame_end;
  logic [FRAME_CNT_W-1:0] w_cnt_inc;
  logic [FRAME_CNT_W-1:0] w_limit;
  seq_state_t             w_state_nxt;
  logic [FRAME_CNT_W-1:0] w_cnt_nxt;

  seq_state_t             r_state;
  logic [FRAME_CNT_W-1:0] r_cnt;
  mode_t                  r_mode;
  logic                   r_blur_en;
  logic                   r_busy;
  logic                   r_done;

  frame_tracker u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .sop       (sop),
    .eop       (eop),
    .valid     (valid),
    .ready     (ready),
    .in_frame  (w_in_frame),
    .frame_end (w_frame_end),
    .proto_err (proto_err)
  );

  assign w_acc     = valid & ready;
  assign w_cnt_inc = r_cnt + FRAME_CNT_W'(1);
  assign w_limit   = (r_state == ST_BLUR) ? BLUR_LIM : RAW_LIM;

  // Next state and counter; abort only takes effect between frames.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (at_table && !w_in_frame && !w_acc && !abort) w_state_nxt = ST_RAW;
      end
      ST_RAW, ST_BLUR: begin
        if (abort && !w_in_frame) begin
          w_state_nxt = ST_REARM;
          w_cnt_nxt   = '0;
        end else if (w_frame_end) begin
          if (abort) begin
            w_state_nxt = ST_REARM;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == w_limit) begin
            w_state_nxt = (r_state == ST_RAW) ? ST_BLUR : ST_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_REARM;
      ST_REARM: begin
        if (!at_table) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mode    <= BLACK;
      r_blur_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mode    <= mode_of(w_state_nxt);
      r_blur_en <= (w_state_nxt == ST_BLUR);
      r_busy    <= (w_state_nxt == ST_RAW) || (w_state_nxt == ST_BLUR) || (w_state_nxt == ST_DONE);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign mode      = r_mode;
  assign blur_en   = r_blur_en;
  assign frame_cnt = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/frame_mode_sequencer.md
FRAME_MODE_SEQUENCER -- requirements
Module: frame_mode_sequencer

Interface
REQ-001 The module SHALL declare parameter RAW_FRAMES, default 1: frames sent unmodified per table visit (legal 1..255).
REQ-002 The module SHALL declare parameter BLUR_FRAMES, default 1: frames sent blurred per table visit (legal 1..255).
REQ-003 The module SHALL use a single clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sop  input  1  start-of-packet of the current stream beat.
- eop  input  1  end-of-packet of the current stream beat.
- valid  input  1  stream beat valid.
- ready  input  1  downstream ready.
- at_table  input  1  level request: robot is at a table.
- abort  input  1  level request: cancel the sequence at the next frame boundary.
- mode  output  2  pixel mux select: 0 = BLACK, 1 = RAW, 2 = BLUR; 3 is never driven.
- blur_en  output  1  enable for the blurring filter.
- frame_cnt  output  8  frames completed in the current state.
- busy  output  1  a sequence is in progress.
- done  output  1  one-cycle pulse when a sequence completes.
- proto_err  output  1  sticky stream protocol violation flag.

Function
REQ-004 An accepted beat SHALL be defined as valid && ready; sop and eop SHALL be ignored on any other cycle.
REQ-005 in_frame SHALL set on an accepted sop and clear on an accepted eop; a beat carrying both sop and eop SHALL leave in_frame at 0.
REQ-006 The state machine SHALL have five states: IDLE, RAW, BLUR, DONE and REARM.
REQ-007 IDLE -> RAW SHALL occur when at_table=1, in_frame=0, no beat is accepted that cycle and abort=0; otherwise IDLE SHALL hold.
REQ-008 In RAW, each accepted eop SHALL increment frame_cnt; the accepted eop that brings the count to RAW_FRAMES SHALL move the FSM to BLUR and clear frame_cnt on that same edge.
REQ-009 BLUR SHALL count the same way and move to DONE on the accepted eop that reaches BLUR_FRAMES, clearing frame_cnt.
REQ-010 DONE SHALL last exactly one cycle, SHALL assert done, and SHALL move unconditionally to REARM.
REQ-011 REARM SHALL move to IDLE when at_table=0, so that a held at_table cannot retrigger a sequence.
REQ-012 abort=1 in RAW or BLUR SHALL move the FSM to REARM:
- immediately, if in_frame=0;
- otherwise on the next accepted eop.
- No done pulse SHALL be produced, and frame_cnt SHALL clear.
REQ-013 mode and blur_en SHALL be registered state decodes: mode = 1 in RAW, 2 in BLUR, 0 otherwise; blur_en=1 only in BLUR.
REQ-014 busy SHALL be 1 in RAW, BLUR and DONE.
REQ-015 Every mode change SHALL take effect on the cycle after the triggering eop, so no frame ever mixes modes.
REQ-016 Deasserting at_table during RAW or BLUR SHALL be ignored; the sequence SHALL complete.
REQ-017 proto_err SHALL set on an accepted sop while in_frame=1, or on an accepted eop while in_frame=0.
REQ-018 proto_err SHALL clear only on reset.
REQ-019 On a sop-while-in_frame error, the new beat SHALL be treated as a frame start and in_frame SHALL remain 1.
REQ-020 frame_cnt SHALL be 8-bit and SHALL never exceed the active limit minus 1 while held in a state.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state=IDLE, in_frame=0, frame_cnt=0, mode=0, blur_en=0, busy=0, done=0 and proto_err=0.
REQ-022 Reset asserted mid-frame SHALL discard the sequence.
REQ-023 After reset, the first accepted sop SHALL be treated as a clean frame start.
REQ-024 Reset release SHALL be synchronised to clk by the instantiating top level; this block SHALL not contain a synchroniser.

Structure
REQ-025 The package image_send_pkg SHALL hold the mode_t enum (BLACK/RAW/BLUR), the seq_state_t enum and the constant FRAME_CNT_W=8.
REQ-026 The in_frame and proto_err logic SHALL live in the sub-module frame_tracker (inputs: sop, eop, valid, ready; outputs: in_frame, frame_end, proto_err).
REQ-027 The FSM and counter SHALL reside in frame_mode_sequencer.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Defaults, at_table held high, three 4-beat frames -> frame 1 mode=1, frame 2 mode=2, frame 3 mode=0; done pulses once on the cycle after frame 2's eop.
- RAW_FRAMES=3, BLUR_FRAMES=2 -> frame_cnt reads 1, 2 in RAW, then 1 in BLUR; mode changes exactly one cycle after the 3rd and 5th eops.
- at_table rises mid-frame (in_frame=1) -> mode stays 0 until that frame's eop, RAW starts with the next frame.
- abort=1 at the 2nd beat of a RAW frame -> REARM after that frame's eop, no done, frame_cnt=0.
- sop, sop without an eop between -> proto_err=1 and stays 1; ready=0 with eop=1 causes no count change; rst_n pulsed mid-BLUR -> all outputs 0 asynchronously.
